// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: EX -> EX/MEM -> MEM channel bundle.
//
// Handshake: in_valid/in_ready and out_valid/out_ready both use strict
// valid/ready rules. A transfer happens on a rising clock edge when valid and
// ready are both high. A producer holding valid=1 keeps its payload stable
// until the transfer. Ready never depends combinationally on valid.
//
// Optional forwarding outputs are compiled in only when EX_MEM_FWD_EN is defined.
// Modport "slave" is the stage itself. Modport "master" is the surrounding
// pipeline, which drives the EX side and the MEM-side ready.
interface ex_mem_stage_if #(
    parameter int DW = 64,
    parameter int RW = 5
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_res;
    logic          alu_z;
    logic          alu_c;
    logic [DW-1:0] store_data;
    logic [DW-1:0] br_target;
    logic [RW-1:0] rd;
    logic [6:0]    ctl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [RW-1:0] mem_rd;
    logic [3:0]    mem_ctl;
    logic          carry;
    logic          br_taken;
    logic [DW-1:0] br_pc;
`ifdef EX_MEM_FWD_EN
    logic          fwd_valid;
    logic [RW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;
`endif

    modport slave (
`ifdef EX_MEM_FWD_EN
        output fwd_valid, fwd_rd, fwd_data,
`endif
        input  flush, in_valid, alu_res, alu_z, alu_c, store_data, br_target,
               rd, ctl, out_ready,
        output in_ready, out_valid, mem_addr, mem_wdata, mem_rd, mem_ctl,
               carry, br_taken, br_pc
    );

    modport master (
`ifdef EX_MEM_FWD_EN
        input  fwd_valid, fwd_rd, fwd_data,
`endif
        output flush, in_valid, alu_res, alu_z, alu_c, store_data, br_target,
               rd, ctl, out_ready,
        input  in_ready, out_valid, mem_addr, mem_wdata, mem_rd, mem_ctl,
               carry, br_taken, br_pc
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register built as a 2-entry elastic buffer
// (head + skid). It resolves CBZ/CBNZ/B at capture time and presents one entry
// per cycle to the MEM stage. Optional macro EX_MEM_FWD_EN adds the
// fwd_valid/fwd_rd/fwd_data forwarding outputs taken from the head entry.
// dbg_count exposes the occupancy state (0 EMPTY, 1 ONE, 2 FULL).
module ex_mem_stage #(
    parameter int DW = 64,
    parameter int RW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_mem_stage_if.slave      bus,
    output logic [1:0]         dbg_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_e;

    typedef struct packed {
        logic [DW-1:0] alu_res;
        logic [DW-1:0] store_data;
        logic [DW-1:0] br_target;
        logic [RW-1:0] rd;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          carry;
        logic          taken;
    } entry_t;

    count_e count_q, count_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   accept;
    logic   pop;

    // Handshake qualifiers. in_ready comes only from a flop, so accept never
    // depends on out_ready in the same cycle.
    always_comb begin
        accept = bus.in_valid & in_ready_q;
        pop    = out_valid_q & bus.out_ready;
    end

    // Pack the incoming EX entry and resolve the branch from the Z flag.
    // Z is consumed here and is not stored.
    always_comb begin
        in_entry            = '0;
        in_entry.alu_res    = bus.alu_res;
        in_entry.store_data = bus.store_data;
        in_entry.br_target  = bus.br_target;
        in_entry.rd         = bus.rd;
        in_entry.reg_write  = bus.ctl[6];
        in_entry.mem_read   = bus.ctl[5];
        in_entry.mem_write  = bus.ctl[4];
        in_entry.mem_to_reg = bus.ctl[3];
        in_entry.carry      = bus.alu_c;
        in_entry.taken      = bus.ctl[0]
                            | (bus.ctl[2] & (bus.ctl[1] ? ~bus.alu_z : bus.alu_z));
    end

    // Occupancy FSM next state and entry movement. Flush drops everything,
    // including an entry offered in the same cycle. Stale entry contents are
    // left in place; the output gating hides them.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            count_d = EMPTY;
        end else begin
            unique case (count_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_entry;
                        count_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        count_d = FULL;
                    end else if (pop) begin
                        count_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can occur.
                    if (pop) begin
                        head_d  = skid_q;
                        count_d = ONE;
                    end
                end
                default: begin
                    count_d = EMPTY;
                end
            endcase
        end
        in_ready_d  = (count_d != FULL);
        out_valid_d = (count_d != EMPTY);
    end

    // State, storage and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Head entry onto the MEM-side bus. Control-like outputs are gated by
    // out_valid so a flushed head can never issue a memory or write-back op.
    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = out_valid_q;
        bus.mem_addr  = head_q.alu_res;
        bus.mem_wdata = head_q.store_data;
        bus.mem_rd    = head_q.rd;
        bus.br_pc     = head_q.br_target;
        bus.mem_ctl   = out_valid_q ? {head_q.reg_write, head_q.mem_read,
                                       head_q.mem_write, head_q.mem_to_reg}
                                    : 4'b0000;
        bus.carry     = out_valid_q & head_q.carry;
        bus.br_taken  = out_valid_q & head_q.taken;
        dbg_count     = count_q;
    end

`ifdef EX_MEM_FWD_EN
    // EX operand forwarding straight from the head register (no added latency).
    always_comb begin
        bus.fwd_valid = out_valid_q & head_q.reg_write & (head_q.rd != '0);
        bus.fwd_rd    = head_q.rd;
        bus.fwd_data  = head_q.alu_res;
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed scenarios plus randomized traffic for ex_mem_stage,
// checked against a queue-based model of the 2-deep stage.
module tb_ex_mem_stage;

    localparam int DW = 64;
    localparam int RW = 5;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_count;

    ex_mem_stage_if #(.DW(DW), .RW(RW)) bus ();

    ex_mem_stage #(.DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_count (dbg_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] pc;
        logic [RW-1:0] rd;
        logic [3:0]    ctl;
        logic          c;
        logic          taken;
    } exp_t;

    exp_t exp_q[$];
    logic model_ready;
    int   checks;
    int   errors;

    // Expected entry for what is currently offered on the EX side.
    function automatic exp_t make_exp();
        exp_t e;
        e.addr  = bus.alu_res;
        e.wdata = bus.store_data;
        e.pc    = bus.br_target;
        e.rd    = bus.rd;
        e.ctl   = bus.ctl[6:3];
        e.c     = bus.alu_c;
        if (bus.ctl[0])       e.taken = 1'b1;
        else if (!bus.ctl[2]) e.taken = 1'b0;
        else if (bus.ctl[1])  e.taken = !bus.alu_z;
        else                  e.taken = bus.alu_z;
        return e;
    endfunction

    // One clock: the model consumes the inputs at the edge, and control returns on the falling edge.
    task automatic tick();
        logic acc;
        logic pp;
        @(posedge clk);
        acc = bus.in_valid && model_ready;
        pp  = (exp_q.size() != 0) && bus.out_ready;
        if (bus.flush) begin
            exp_q.delete();
        end else begin
            if (pp) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(make_exp());
        end
        model_ready = (exp_q.size() < 2);
        @(negedge clk);
    endtask

    // Driver
    task automatic drive(input logic v, input logic [DW-1:0] res,
                         input logic [DW-1:0] wd, input logic [DW-1:0] tgt,
                         input logic [RW-1:0] r, input logic [6:0] c,
                         input logic z, input logic cy);
        bus.in_valid   = v;
        bus.alu_res    = res;
        bus.store_data = wd;
        bus.br_target  = tgt;
        bus.rd         = r;
        bus.ctl        = c;
        bus.alu_z      = z;
        bus.alu_c      = cy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready, dbg_count} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_hs: got valid/ready/count=%b expected 0100",
                     {bus.out_valid, bus.in_ready, dbg_count});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.br_pc, bus.mem_rd, bus.mem_ctl,
             bus.carry, bus.br_taken} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0h wdata=%0h pc=%0h rd=%0d ctl=%b expected all 0",
                     bus.mem_addr, bus.mem_wdata, bus.br_pc, bus.mem_rd, bus.mem_ctl);
        end
        rst_n = 1'b1;
        exp_q.delete();
        model_ready = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_idle: got valid/ready=%b expected 01",
                     {bus.out_valid, bus.in_ready});
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        drive(1'b1, 64'h10, 64'h0, 64'h0, 5'd3, 7'b1000000, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.out_valid, bus.mem_addr, bus.mem_rd, bus.mem_ctl} !==
            {1'b1, 64'h10, 5'd3, 4'b1000}) begin
            errors++;
            $display("FAIL basic_capture: got v=%b addr=%0h rd=%0d ctl=%b expected v=1 addr=10 rd=3 ctl=1000",
                     bus.out_valid, bus.mem_addr, bus.mem_rd, bus.mem_ctl);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if ({bus.out_valid, bus.mem_ctl} !== 5'b0) begin
            errors++;
            $display("FAIL basic_drain: got v=%b ctl=%b expected v=0 ctl=0000",
                     bus.out_valid, bus.mem_ctl);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        drive(1'b1, 64'd1, 64'h0, 64'h0, 5'd1, 7'b1000000, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.mem_addr} !== {1'b1, 1'b1, 64'd1}) begin
            errors++;
            $display("FAIL b2b_a: got ready=%b v=%b addr=%0h expected ready=1 v=1 addr=1",
                     bus.in_ready, bus.out_valid, bus.mem_addr);
        end
        bus.alu_res = 64'd2;
        tick();
        checks++;
        if ({bus.in_ready, dbg_count, bus.mem_addr} !== {1'b0, 2'd2, 64'd1}) begin
            errors++;
            $display("FAIL b2b_b: got ready=%b count=%0d addr=%0h expected ready=0 count=2 addr=1",
                     bus.in_ready, dbg_count, bus.mem_addr);
        end
        bus.alu_res = 64'd3;
        tick();
        checks++;
        if ({bus.in_ready, bus.mem_addr} !== {1'b0, 64'd1}) begin
            errors++;
            $display("FAIL b2b_c_held: got ready=%b addr=%0h expected ready=0 addr=1",
                     bus.in_ready, bus.mem_addr);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.mem_addr} !== {1'b1, 1'b1, 64'd2}) begin
            errors++;
            $display("FAIL b2b_second: got v=%b ready=%b addr=%0h expected v=1 ready=1 addr=2",
                     bus.out_valid, bus.in_ready, bus.mem_addr);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.mem_addr} !== {1'b1, 64'd3}) begin
            errors++;
            $display("FAIL b2b_third: got v=%b addr=%0h expected v=1 addr=3",
                     bus.out_valid, bus.mem_addr);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_branch();
        logic [6:0] ctls [5]  = '{7'b0000100, 7'b0000110, 7'b0000110, 7'b0000001, 7'b0000100};
        logic       zs   [5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       want [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h0, 64'h0, 64'h400 + 64'(i * 16), 5'd0, ctls[i], zs[i], 1'b0);
            tick();
            checks++;
            if ({bus.br_taken, bus.br_pc} !== {want[i], 64'h400 + 64'(i * 16)}) begin
                errors++;
                $display("FAIL branch_%0d: got taken=%b pc=%0h expected taken=%b pc=%0h",
                         i, bus.br_taken, bus.br_pc, want[i], 64'h400 + 64'(i * 16));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.br_taken !== 1'b0) begin
            errors++;
            $display("FAIL branch_idle: got taken=%b expected 0", bus.br_taken);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 64'hA1, 64'hB1, 64'hC1, 5'd4, 7'b1111001, 1'b0, 1'b1);
        tick();
        bus.alu_res = 64'hA2;
        tick();
        bus.alu_res = 64'hA3;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.mem_ctl, bus.carry, bus.br_taken} !== 8'b01000000) begin
            errors++;
            $display("FAIL flush_state: got v=%b ready=%b ctl=%b c=%b taken=%b expected v=0 ready=1 ctl=0000 c=0 taken=0",
                     bus.out_valid, bus.in_ready, bus.mem_ctl, bus.carry, bus.br_taken);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_replay_%0d: got v=%b addr=%0h expected v=0",
                         i, bus.out_valid, bus.mem_addr);
            end
        end
        drive(1'b1, 64'h77, 64'h0, 64'h0, 5'd9, 7'b1000000, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.out_valid, bus.mem_addr} !== {1'b1, 64'h77}) begin
            errors++;
            $display("FAIL flush_recover: got v=%b addr=%0h expected v=1 addr=77",
                     bus.out_valid, bus.mem_addr);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, 64'h55, 64'h66, 64'h88, 5'd12, 7'b1110001, 1'b0, 1'b1);
        tick();
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, dbg_count, bus.mem_ctl, bus.br_taken, bus.carry} !== 10'b0100000000) begin
            errors++;
            $display("FAIL async_reset_hs: got v=%b ready=%b count=%0d ctl=%b expected v=0 ready=1 count=0 ctl=0000",
                     bus.out_valid, bus.in_ready, dbg_count, bus.mem_ctl);
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.br_pc, bus.mem_rd} !== '0) begin
            errors++;
            $display("FAIL async_reset_data: got addr=%0h wdata=%0h pc=%0h rd=%0d expected 0",
                     bus.mem_addr, bus.mem_wdata, bus.br_pc, bus.mem_rd);
        end
        exp_q.delete();
        model_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_discard: got v=%b expected 0", bus.out_valid);
        end
    endtask

`ifdef EX_MEM_FWD_EN
    task automatic test_fwd();
        bus.out_ready = 1'b1;
        drive(1'b1, 64'h99, 64'h0, 64'h0, 5'd0, 7'b1000000, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_rd0: got fwd_valid=%b expected 0", bus.fwd_valid);
        end
        drive(1'b1, 64'h1234, 64'h0, 64'h0, 5'd7, 7'b1000000, 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== {1'b1, 5'd7, 64'h1234}) begin
            errors++;
            $display("FAIL fwd_rd7: got v=%b rd=%0d data=%0h expected v=1 rd=7 data=1234",
                     bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.out_ready = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, 5'($urandom_range(0, 31)),
                  7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            checks++;
            if ({bus.out_valid, bus.in_ready} !== {exp_q.size() != 0, model_ready}) begin
                errors++;
                $display("FAIL rand_hs_%0d: got v=%b ready=%b expected v=%b ready=%b",
                         i, bus.out_valid, bus.in_ready, exp_q.size() != 0, model_ready);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if ({bus.mem_addr, bus.mem_wdata, bus.br_pc, bus.mem_rd, bus.mem_ctl,
                     bus.carry, bus.br_taken} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand_head_%0d: got %h expected %h", i,
                             {bus.mem_addr, bus.mem_wdata, bus.br_pc, bus.mem_rd,
                              bus.mem_ctl, bus.carry, bus.br_taken}, exp_q[0]);
                end
`ifdef EX_MEM_FWD_EN
                checks++;
                if (bus.fwd_valid !== (exp_q[0].ctl[3] && exp_q[0].rd != 0)) begin
                    errors++;
                    $display("FAIL rand_fwd_%0d: got %b expected %b", i, bus.fwd_valid,
                             exp_q[0].ctl[3] && exp_q[0].rd != 0);
                end
`endif
            end else begin
                checks++;
                if ({bus.mem_ctl, bus.carry, bus.br_taken} !== 6'b0) begin
                    errors++;
                    $display("FAIL rand_idle_%0d: got ctl=%b c=%b taken=%b expected all 0",
                             i, bus.mem_ctl, bus.carry, bus.br_taken);
                end
            end
        end
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
    endtask

    // Test sequence and final report
    initial begin
        checks = 0;
        errors = 0;
        model_ready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_branch();
        test_flush();
        test_async_reset();
`ifdef EX_MEM_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
